blk_mem_gen_1: RTL and testbench

BLK_MEM_GEN_1 -- requirements
Module: blk_mem_gen_1

---
 rtl/blk_mem_gen_1_pkg.sv | 16 +
 rtl/blk_mem_gen_1.sv | 52 +++++
 tb/tb_blk_mem_gen_1.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/blk_mem_gen_1_pkg.sv
// -----------------------------------------------------------------------------
// blk_mem_gen_1_pkg
// Shared block-RAM geometry constants. The single-lane RAM (blk_mem_gen_1)
// takes its parameter defaults from here, and the 8-lane 64-bit data memory
// wrapper reuses the same values so every byte lane is sized identically.
// -----------------------------------------------------------------------------
package blk_mem_gen_1_pkg;

  // Word address width of one RAM lane.
  localparam int BRAM_ADDR_W = 13;
  // Width of one byte lane.
  localparam int BRAM_DATA_W = 8;
  // Number of words in one lane (2**BRAM_ADDR_W).
  localparam int BRAM_DEPTH  = 8192;

endpackage : blk_mem_gen_1_pkg

// File: rtl/blk_mem_gen_1.sv
// -----------------------------------------------------------------------------
// blk_mem_gen_1
// Simple dual-port RAM, DEPTH x DATA_W, one clock. Port A is write-only and
// port B is read-only with a single registered output (1-cycle latency,
// read-first on a same-address collision). Written in the canonical
// block-RAM inference template: one array, one output register.
//
// Ports
//   clk   : in  1       single clock, rising edge active
//   rst   : in  1       synchronous active-high reset; clears doutb and
//                       suppresses writes, memory contents are retained
//   wea   : in  1       port A write enable
//   addra : in  ADDR_W  port A write word address
//   dina  : in  DATA_W  port A write data
//   addrb : in  ADDR_W  port B read word address
//   doutb : out DATA_W  port B registered read data
// -----------------------------------------------------------------------------
module blk_mem_gen_1
  import blk_mem_gen_1_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DEPTH  = BRAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  // Storage is zeroed by the configuration image, never by rst, so data
  // written before a reset survives it.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Write port A and register port B. Both use non-blocking assignments in
  // the same process, so a same-address read samples the pre-write word
  // (read-first); the new word is visible on the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb <= '0;
    end else begin
      if (wea) begin
        mem[addra] <= dina;
      end
      doutb <= mem[addrb];
    end
  end

endmodule : blk_mem_gen_1

// File: tb/tb_blk_mem_gen_1.sv
// -----------------------------------------------------------------------------
// tb_blk_mem_gen_1
// Directed vectors with hand-computed expectations for blk_mem_gen_1, followed
// by random write/read traffic checked against a read-first reference array.
// -----------------------------------------------------------------------------
module tb_blk_mem_gen_1;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DP = 8192;

  logic          clk;
  logic          rst;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;

  int n_cmp;
  int n_bad;

  // Reference contents, updated alongside every write the bench issues.
  logic [DW-1:0] ref_mem [DP];
  logic [DW-1:0] exp_rd;

  blk_mem_gen_1 #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (DP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .addrb(addrb),
    .doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, and keep the reference
  // model in step. exp_rd holds the read-first model value for this edge.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic [AW-1:0] ab);
    rst   = r;
    wea   = we;
    addra = aa;
    dina  = da;
    addrb = ab;
    exp_rd = r ? 8'h00 : ref_mem[ab];
    if (!r && we) ref_mem[aa] = da;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < DP; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; wea = 1'b0; addra = '0; dina = '0; addrb = '0;

    // Reset for two cycles.
    step(1'b1, 1'b0, 13'h0000, 8'h00, 13'h0000);
    step(1'b1, 1'b0, 13'h0000, 8'h00, 13'h0000);
    check_val("reset_dout", doutb, 8'h00);

    // Basic write then read.
    step(1'b0, 1'b1, 13'h0010, 8'hA5, 13'h0000);
    check_val("init_read_0", doutb, 8'h00);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0010);
    check_val("basic_rd_10", doutb, 8'hA5);

    // Read-first collision.
    step(1'b0, 1'b1, 13'h0020, 8'h11, 13'h0010);
    step(1'b0, 1'b1, 13'h0020, 8'h22, 13'h0020);
    check_val("collide_old", doutb, 8'h11);
    step(1'b0, 1'b0, 13'h0020, 8'h22, 13'h0020);
    check_val("collide_new", doutb, 8'h22);

    // Address boundaries, no aliasing.
    step(1'b0, 1'b1, 13'h1FFF, 8'h7E, 13'h0000);
    step(1'b0, 1'b1, 13'h0000, 8'h81, 13'h1FFF);
    check_val("bound_hi", doutb, 8'h7E);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0000);
    check_val("bound_lo", doutb, 8'h81);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0FFF);
    check_val("alias_0fff", doutb, 8'h00);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h1000);
    check_val("alias_1000", doutb, 8'h00);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h1FFE);
    check_val("alias_1ffe", doutb, 8'h00);

    // Write-enable gating.
    step(1'b0, 1'b0, 13'h0030, 8'hFF, 13'h0000);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0030);
    check_val("wea_gate", doutb, 8'h00);

    // Reset suppresses write and clears doutb, memory retained.
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0010);
    check_val("pre_rst_rd", doutb, 8'hA5);
    step(1'b1, 1'b1, 13'h0010, 8'h5A, 13'h0010);
    check_val("rst_clear", doutb, 8'h00);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h0010);
    check_val("rst_retain", doutb, 8'hA5);

    // Held output: no edge-independent change within the cycle.
    #3;
    check_val("hold_dout", doutb, 8'hA5);

    // Reset arriving mid-read discards it.
    step(1'b1, 1'b0, 13'h0000, 8'h00, 13'h1FFF);
    check_val("rst_midread", doutb, 8'h00);
    step(1'b0, 1'b0, 13'h0000, 8'h00, 13'h1FFF);
    check_val("first_after_rst", doutb, 8'h7E);

    // Random traffic: small address window half the time for collisions.
    for (int k = 0; k < 10000; k++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      if ($urandom_range(0, 1) == 0) begin
        ra = AW'($urandom_range(0, 15));
        rb = AW'($urandom_range(0, 15));
      end else begin
        ra = AW'($urandom_range(0, DP - 1));
        rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DP - 1));
      end
      step(1'b0, 1'($urandom_range(0, 1)), ra, DW'($urandom_range(0, 255)), rb);
      check_val("random_rd", doutb, exp_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_blk_mem_gen_1
